// File: rtl/bob_except_banked_if.sv
// Signal bundle for the banked retire-buffer exception store: execution-port writes,
// whole-row init, flush, and the retire-side row read.
interface bob_except_banked_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BANKS      = 10,
  parameter int unsigned ENTRIES    = 48,
  parameter int unsigned WPORTS     = 9
);
  localparam int unsigned BW = $clog2(BANKS);
  localparam int unsigned RW = $clog2(ENTRIES);
  localparam int unsigned AW = RW + BW;

  logic [WPORTS-1:0]            wr_en;
  logic [WPORTS*AW-1:0]         wr_addr;
  logic [WPORTS*DATA_WIDTH-1:0] wr_data;
  logic                         init_en;
  logic [RW-1:0]                init_addr;
  logic [BANKS*DATA_WIDTH-1:0]  init_data;
  logic [BANKS-1:0]             init_vmask;
  logic                         flush;
  logic                         read_step;
  logic [RW-1:0]                read_addr;
  logic [BANKS*DATA_WIDTH-1:0]  read_data;
  logic [BANKS-1:0]             read_valid;
  logic                         read_any;
  logic                         wr_oob;

  modport master (
    output wr_en, wr_addr, wr_data, init_en, init_addr, init_data, init_vmask,
    output flush, read_step, read_addr,
    input  read_data, read_valid, read_any, wr_oob
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, init_en, init_addr, init_data, init_vmask,
    input  flush, read_step, read_addr,
    output read_data, read_valid, read_any, wr_oob
  );
endinterface

// File: rtl/bob_except_banked.sv
// Per-bank exception store for retire-buffer rows: multi-port bank writes, whole-row init,
// per-entry valid bits with flush, latched-row read, and a sticky out-of-range write flag.
module bob_except_banked #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BANKS      = 10,
  parameter int unsigned ENTRIES    = 48,
  parameter int unsigned WPORTS     = 9
) (
  input logic                clk,
  input logic                rst,
  bob_except_banked_if.slave bus
);
  localparam int unsigned BW = $clog2(BANKS);
  localparam int unsigned RW = $clog2(ENTRIES);
  localparam int unsigned AW = RW + BW;

  logic [DATA_WIDTH-1:0] mem_q   [ENTRIES][BANKS];
  logic [BANKS-1:0]      valid_q [ENTRIES];
  logic [RW-1:0]         rd_addr_q;
  logic                  oob_q;

  logic [RW-1:0]         port_row  [WPORTS];
  logic [BW-1:0]         port_bank [WPORTS];
  logic [DATA_WIDTH-1:0] port_data [WPORTS];
  logic [WPORTS-1:0]     port_ok;
  logic                  init_ok;
  logic                  oob_hit;

  always_comb begin
    oob_hit = 1'b0;
    for (int p = 0; p < WPORTS; p++) begin
      port_row[p]  = bus.wr_addr[p*AW+BW +: RW];
      port_bank[p] = bus.wr_addr[p*AW +: BW];
      port_data[p] = bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
      port_ok[p]   = bus.wr_en[p] &&
                     ({1'b0, port_row[p]} < (RW+1)'(ENTRIES)) &&
                     ({1'b0, port_bank[p]} < (BW+1)'(BANKS));
      if (bus.wr_en[p] && !port_ok[p]) oob_hit = 1'b1;
    end
    init_ok = bus.init_en && ({1'b0, bus.init_addr} < (RW+1)'(ENTRIES));
    if (bus.init_en && !init_ok) oob_hit = 1'b1;
  end

  // Later assignments win: port order gives ascending priority, init is highest.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WPORTS; p++) begin
      if (port_ok[p]) mem_q[port_row[p]][port_bank[p]] <= port_data[p];
    end
    if (init_ok) begin
      for (int k = 0; k < BANKS; k++) begin
        mem_q[bus.init_addr][k] <= bus.init_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Flush clears first so same-cycle writes survive it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) valid_q[e] <= '0;
    end else begin
      if (bus.flush) begin
        for (int e = 0; e < ENTRIES; e++) valid_q[e] <= '0;
      end
      for (int p = 0; p < WPORTS; p++) begin
        if (port_ok[p]) valid_q[port_row[p]][port_bank[p]] <= 1'b1;
      end
      if (init_ok) valid_q[bus.init_addr] <= bus.init_vmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q <= '0;
      oob_q     <= 1'b0;
    end else begin
      if (bus.read_step) rd_addr_q <= bus.read_addr;
      if (oob_hit)       oob_q     <= 1'b1;
    end
  end

  always_comb begin
    bus.read_data = '0;
    for (int k = 0; k < BANKS; k++) begin
      bus.read_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr_q][k];
    end
    bus.read_valid = valid_q[rd_addr_q];
    bus.read_any   = |valid_q[rd_addr_q];
    bus.wr_oob     = oob_q;
  end
endmodule

// File: tb/tb_bob_except_banked.sv
// Directed bench for bob_except_banked: a table of single-port writes with read-back,
// plus hand sequences for collisions, flush, held read row, and sticky out-of-range.
module tb_bob_except_banked;
  localparam int unsigned DW = 8;
  localparam int unsigned NB = 10;
  localparam int unsigned NE = 48;
  localparam int unsigned NP = 9;
  localparam int unsigned BW = 4;
  localparam int unsigned RW = 6;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bob_except_banked_if #(.DATA_WIDTH(DW), .BANKS(NB), .ENTRIES(NE), .WPORTS(NP)) bus ();

  bob_except_banked #(.DATA_WIDTH(DW), .BANKS(NB), .ENTRIES(NE), .WPORTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           port;
    int           row;
    int           bank;
    logic [7:0]   data;
    int           rd_row;
    bit           chk_data;
    logic [9:0]   exp_valid;
    bit           exp_oob;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.init_en    = 1'b0;
    bus.init_addr  = '0;
    bus.init_data  = '0;
    bus.init_vmask = '0;
    bus.flush      = 1'b0;
    bus.read_step  = 1'b0;
  endtask

  task automatic set_port(input int p, input int row, input int bank, input logic [7:0] data);
    logic [RW-1:0] r;
    logic [BW-1:0] b;
    r = RW'(row);
    b = BW'(bank);
    bus.wr_en[p]             = 1'b1;
    bus.wr_addr[p*AW +: AW]  = {r, b};
    bus.wr_data[p*DW +: DW]  = data;
  endtask

  task automatic read_row(input int row);
    bus.read_step = 1'b1;
    bus.read_addr = RW'(row);
    tick();
    bus.read_step = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] bank_of(input int k);
    return bus.read_data[k*DW +: DW];
  endfunction

  initial begin
    vecs[0] = '{3,  5,  2, 8'hA5, 5,  1'b1, 10'h004, 1'b0};
    vecs[1] = '{0,  5,  0, 8'h3C, 5,  1'b1, 10'h005, 1'b0};
    vecs[2] = '{8,  47, 9, 8'h5A, 47, 1'b1, 10'h200, 1'b0};
    vecs[3] = '{2,  20, 3, 8'hEE, 20, 1'b1, 10'h008, 1'b0};
    vecs[4] = '{6,  20, 3, 8'hD1, 20, 1'b1, 10'h008, 1'b0};
    vecs[5] = '{0,  3, 12, 8'h77, 3,  1'b0, 10'h000, 1'b1};
    vecs[6] = '{4,  50, 1, 8'h42, 3,  1'b0, 10'h000, 1'b1};

    clear_inputs();
    bus.read_addr = '0;
    do_reset();

    // Reset state
    read_row(0);
    check("reset_valid", 32'(bus.read_valid), 32'h0);
    check("reset_any", 32'(bus.read_any), 32'h0);
    check("reset_oob", 32'(bus.wr_oob), 32'h0);

    // Table-driven single-port writes
    foreach (vecs[i]) begin
      clear_inputs();
      set_port(vecs[i].port, vecs[i].row, vecs[i].bank, vecs[i].data);
      tick();
      clear_inputs();
      read_row(vecs[i].rd_row);
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), 32'(bank_of(vecs[i].bank)),
                                  32'(vecs[i].data));
      check($sformatf("vec%0d_valid", i), 32'(bus.read_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_any", i), 32'(bus.read_any), 32'(vecs[i].exp_valid != 0));
      check($sformatf("vec%0d_oob", i), 32'(bus.wr_oob), 32'(vecs[i].exp_oob));
    end

    // Ports 1 and 7 collide: higher port wins
    clear_inputs();
    set_port(1, 9, 4, 8'h11);
    set_port(7, 9, 4, 8'h77);
    tick();
    clear_inputs();
    read_row(9);
    check("coll_port_data", 32'(bank_of(4)), 32'h77);
    check("coll_port_valid", 32'(bus.read_valid), 32'h010);

    // Init beats both ports on the same entry
    set_port(1, 9, 4, 8'h11);
    set_port(7, 9, 4, 8'h77);
    bus.init_en    = 1'b1;
    bus.init_addr  = 6'd9;
    bus.init_data  = {NB{8'h99}};
    bus.init_vmask = 10'h010;
    tick();
    clear_inputs();
    check("coll_init_data4", 32'(bank_of(4)), 32'h99);
    check("coll_init_data0", 32'(bank_of(0)), 32'h99);
    check("coll_init_valid", 32'(bus.read_valid), 32'h010);

    // Full init then flush with a same-cycle write
    bus.init_en    = 1'b1;
    bus.init_addr  = 6'd12;
    bus.init_data  = {NB{8'h4B}};
    bus.init_vmask = 10'h3FF;
    tick();
    clear_inputs();
    read_row(12);
    check("init_full_valid", 32'(bus.read_valid), 32'h3FF);
    check("init_full_data7", 32'(bank_of(7)), 32'h4B);
    bus.flush = 1'b1;
    set_port(0, 12, 0, 8'hC7);
    tick();
    clear_inputs();
    check("flush_wr_valid", 32'(bus.read_valid), 32'h001);
    check("flush_wr_data", 32'(bank_of(0)), 32'hC7);
    read_row(5);
    check("flush_other_valid", 32'(bus.read_valid), 32'h0);
    check("flush_other_any", 32'(bus.read_any), 32'h0);

    // Latched row holds while a write to it becomes visible next cycle
    read_row(7);
    check("hold_pre_valid", 32'(bus.read_valid), 32'h0);
    bus.read_addr = 6'd3;
    set_port(5, 7, 9, 8'hC3);
    tick();
    clear_inputs();
    check("hold_data9", 32'(bank_of(9)), 32'hC3);
    check("hold_valid", 32'(bus.read_valid), 32'h200);
    tick();
    check("hold_still_row7", 32'(bus.read_valid), 32'h200);

    // Sticky oob survives flush; cleared only by reset
    bus.flush = 1'b1;
    tick();
    clear_inputs();
    check("oob_sticky", 32'(bus.wr_oob), 32'h1);
    do_reset();
    check("oob_rst", 32'(bus.wr_oob), 32'h0);
    read_row(47);
    check("rst_valid47", 32'(bus.read_valid), 32'h0);

    // Init to a row past the end sets oob, touches nothing
    bus.init_en    = 1'b1;
    bus.init_addr  = 6'd60;
    bus.init_vmask = 10'h3FF;
    tick();
    clear_inputs();
    check("init_oob", 32'(bus.wr_oob), 32'h1);
    check("init_oob_valid", 32'(bus.read_valid), 32'h0);

    // Reset overrides a same-cycle write for valid state
    rst = 1'b1;
    set_port(2, 47, 1, 8'h10);
    tick();
    clear_inputs();
    rst = 1'b0;
    check("rst_over_wr_valid", 32'(bus.read_valid), 32'h0);
    check("rst_over_wr_oob", 32'(bus.wr_oob), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
